// File: rtl/jtgng_romslot.sv
// jtgng_romslot - time-division SDRAM ROM read scheduler.
//
// Serves up to 7 read channels from one 16-bit SDRAM port. A run-time slot
// table maps each slot of a round to a channel, an idle slot or a refresh
// slot. On every cen strobe the code of the current slot is decoded and
// issued, and the slot counter advances (or restarts at 0 on slot_sync).
// Read data is captured LAT clocks after sdram_rd into the channel's
// output register, with a one-clock ch_valid strobe.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cen               slot advance strobe (period >= LAT+1 clk)
//   slot_sync         on cen: next slot is 0
//   downloading       ROM load in progress, scheduler held in reset
//   slot_map          3 bits per slot: 0..CH-1 channel, CH..6 idle, 7 refresh
//   ch_addr/offset    per-channel address and SDRAM word base offset
//   ch_byte           per-channel 8-bit mode (address is a byte address)
//   data_read         SDRAM read data
//   sdram_addr/rd     word address and one-clock read request
//   autorefresh       one-clock refresh request
//   ch_dout/ch_valid  per-channel data and update strobe
//   ready             set after RDYW cen strobes since reset/download
//
// Optional feature: define JTGNG_ROMSLOT_REUSE_EN to keep the last word
// address and data per channel; a channel slot that hits its stored word
// (with the previous fetch complete) is served without an SDRAM read.

module jtgng_romslot #(
    parameter int SLOTS = 16,
    parameter int CH    = 6,
    parameter int AW    = 22,
    parameter int LAT   = 2,
    parameter int RDYW  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               slot_sync,
    input  logic               downloading,
    input  logic [3*SLOTS-1:0] slot_map,
    input  logic [CH*AW-1:0]   ch_addr,
    input  logic [CH*AW-1:0]   ch_offset,
    input  logic [CH-1:0]      ch_byte,
    input  logic [15:0]        data_read,
    output logic [AW-1:0]      sdram_addr,
    output logic               sdram_rd,
    output logic               autorefresh,
    output logic [CH*16-1:0]   ch_dout,
    output logic [CH-1:0]      ch_valid,
    output logic               ready
);
    localparam int SW = $clog2(SLOTS);
    localparam int RW = $clog2(RDYW + 1);
    localparam logic [2:0]    CODE_REF = 3'd7;
    localparam logic [2:0]    CH_CODES = 3'(CH);
    localparam logic [RW-1:0] RDY_MAX  = RW'(RDYW);
    localparam logic [RW-1:0] RDY_PRE  = RW'(RDYW - 1);

    typedef struct packed {
        logic       vld;
        logic       reuse;
        logic       byte_ch;
        logic       lsb;
        logic [2:0] k;
    } pipe_t;

    logic [SW-1:0] slot;
    logic [RW-1:0] rdy_cnt;
    pipe_t         pipe [LAT];
    pipe_t         cap;
    logic          halt;
    logic [2:0]    code;
    logic          is_ch;
    logic [AW-1:0] sel_addr, sel_off, word_addr, calc_addr;
    logic          sel_byte;
    logic          hit;
    logic [15:0]   reuse_word, cap_word, cap_data;

    assign halt  = rst | downloading;
    assign code  = slot_map[3*slot +: 3];
    assign is_ch = code < CH_CODES;

    always_comb begin
        sel_addr = '0;
        sel_off  = '0;
        sel_byte = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (code == 3'(i)) begin
                sel_addr = ch_addr[i*AW +: AW];
                sel_off  = ch_offset[i*AW +: AW];
                sel_byte = ch_byte[i];
            end
        end
    end

    // byte channels address 16-bit words with addr>>1; the sum wraps at 2^AW
    assign word_addr = sel_byte ? {1'b0, sel_addr[AW-1:1]} : sel_addr;
    assign calc_addr = sel_off + word_addr;

    // oldest pipe entry: its data is on data_read this clock
    assign cap      = pipe[LAT-1];
    assign cap_word = cap.reuse ? reuse_word : data_read;
    assign cap_data = cap.byte_ch ? {8'd0, cap.lsb ? cap_word[7:0] : cap_word[15:8]}
                                  : cap_word;

`ifdef JTGNG_ROMSLOT_REUSE_EN
    logic [AW-1:0] last_addr [CH];
    logic [15:0]   last_word [CH];
    logic [CH-1:0] last_ok;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (is_ch && code == 3'(i) && last_ok[i] && last_addr[i] == calc_addr)
                hit = 1'b1;
        end
    end

    always_comb begin
        reuse_word = data_read;
        for (int i = 0; i < CH; i++) begin
            if (cap.k == 3'(i)) reuse_word = last_word[i];
        end
    end

    // last_ok clears at issue so a word is only reused once its fetch landed
    always_ff @(posedge clk) begin
        if (halt) begin
            last_ok <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (cap.vld && !cap.reuse && cap.k == 3'(i)) begin
                    last_word[i] <= data_read;
                    last_ok[i]   <= 1'b1;
                end
                if (cen && is_ch && !hit && code == 3'(i)) begin
                    last_addr[i] <= calc_addr;
                    last_ok[i]   <= 1'b0;
                end
            end
        end
    end
`else
    assign hit        = 1'b0;
    assign reuse_word = data_read;
`endif

    always_ff @(posedge clk) begin
        if (halt) begin
            slot        <= '0;
            sdram_addr  <= '0;
            sdram_rd    <= 1'b0;
            autorefresh <= 1'b0;
            ch_dout     <= '0;
            ch_valid    <= '0;
            ready       <= 1'b0;
            rdy_cnt     <= '0;
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            sdram_rd    <= 1'b0;
            autorefresh <= 1'b0;
            ch_valid    <= '0;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            pipe[0] <= '0;
            for (int i = 0; i < CH; i++) begin
                if (cap.vld && cap.k == 3'(i)) begin
                    ch_dout[i*16 +: 16] <= cap_data;
                    ch_valid[i]         <= 1'b1;
                end
            end
            if (cen) begin
                slot <= slot_sync ? '0 : slot + 1'b1;
                if (rdy_cnt != RDY_MAX) rdy_cnt <= rdy_cnt + 1'b1;
                if (rdy_cnt == RDY_PRE) ready <= 1'b1;
                if (is_ch) begin
                    pipe[0] <= '{vld: 1'b1, reuse: hit, byte_ch: sel_byte,
                                 lsb: sel_addr[0], k: code};
                    if (!hit) begin
                        sdram_rd   <= 1'b1;
                        sdram_addr <= calc_addr;
                    end
                end else if (code == CODE_REF) begin
                    autorefresh <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtgng_romslot.sv
// Self-checking bench for jtgng_romslot: SDRAM data model, a slot-level
// reference model checked every clock, a vector table for address/data
// mapping and directed sequences for refresh, slot_sync and downloading.
module tb_jtgng_romslot;
    localparam int SLOTS = 4, CH = 3, AW = 22, LAT = 2, RDYW = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1, cen = 1'b0, slot_sync = 1'b0, downloading = 1'b0;
    logic [3*SLOTS-1:0] slot_map = '0;
    logic [CH*AW-1:0]   ch_addr = '0, ch_offset = '0;
    logic [CH-1:0]      ch_byte = '0;
    logic [15:0]        data_read = '0;
    logic [AW-1:0]      sdram_addr;
    logic               sdram_rd, autorefresh, ready;
    logic [CH*16-1:0]   ch_dout;
    logic [CH-1:0]      ch_valid;

    always #5 clk = ~clk;

    jtgng_romslot #(.SLOTS(SLOTS), .CH(CH), .AW(AW), .LAT(LAT), .RDYW(RDYW)) dut (
        .clk(clk), .rst(rst), .cen(cen), .slot_sync(slot_sync), .downloading(downloading),
        .slot_map(slot_map), .ch_addr(ch_addr), .ch_offset(ch_offset), .ch_byte(ch_byte),
        .data_read(data_read), .sdram_addr(sdram_addr), .sdram_rd(sdram_rd),
        .autorefresh(autorefresh), .ch_dout(ch_dout), .ch_valid(ch_valid), .ready(ready));

    int n_chk = 0, n_pass = 0, cyc = 0;
    bit fixed_en = 0;
    logic [15:0] fixed_data = '0;

    typedef struct { int due; int ch; logic [15:0] val; bit real_f; } cap_t;
    typedef struct { int due; logic [AW-1:0] addr; } rd_t;
    cap_t capq[$];
    rd_t  rdq[$];

    int m_slot = 0, m_cnt = 0;
    bit m_ready = 0, e_rd = 0, e_ar = 0;
    logic [AW-1:0] m_addr = '0;
    logic [15:0]   m_dout [CH];
    logic [AW-1:0] m_last [CH];
    bit            m_ok [CH];

    function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
        logic [15:0] h;
        if (fixed_en) return fixed_data;
        h = a[15:0] * 16'h9E37;
        return h ^ {a[21:16], 10'h1B3};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    endtask

    task automatic set_ch(input int k, input logic [AW-1:0] a, input logic [AW-1:0] off, input bit byt);
        ch_addr[k*AW +: AW]   = a;
        ch_offset[k*AW +: AW] = off;
        ch_byte[k]            = byt;
    endtask

    // one clock: drive inputs at negedge, advance the model, check at next negedge
    task automatic tick(input bit c, input bit sy, input bit dl, input bit r);
        logic [15:0]      d, val;
        logic [CH-1:0]    ev;
        logic [CH*16-1:0] edout;
        logic [AW-1:0]    ia;
        longint           a, off, w;
        int               code, k;
        bit               hit;
        cen = c; slot_sync = sy; downloading = dl; rst = r;
        d = 16'($urandom);
        foreach (rdq[i]) if (rdq[i].due == cyc) d = mem_word(rdq[i].addr);
        data_read = d;
        while (rdq.size() > 0 && rdq[0].due <= cyc) void'(rdq.pop_front());
        e_rd = 0; e_ar = 0; ev = '0;
        if (r || dl) begin
            m_slot = 0; m_cnt = 0; m_ready = 0; m_addr = '0;
            capq.delete();
            for (int i = 0; i < CH; i++) begin m_dout[i] = '0; m_ok[i] = 0; end
        end else begin
            for (int i = capq.size() - 1; i >= 0; i--) begin
                if (capq[i].due == cyc + 1) begin
                    ev[capq[i].ch] = 1'b1;
                    m_dout[capq[i].ch] = capq[i].val;
                    if (capq[i].real_f) m_ok[capq[i].ch] = 1;
                    capq.delete(i);
                end
            end
            if (c) begin
                code = int'(slot_map[m_slot*3 +: 3]);
                if (code < CH) begin
                    k   = code;
                    a   = longint'(ch_addr[k*AW +: AW]);
                    off = longint'(ch_offset[k*AW +: AW]);
                    w   = ch_byte[k] ? a / 2 : a;
                    ia  = AW'((off + w) % (longint'(1) << AW));
                    hit = 0;
`ifdef JTGNG_ROMSLOT_REUSE_EN
                    hit = m_ok[k] && (m_last[k] == ia);
`endif
                    if (!hit) begin e_rd = 1; m_addr = ia; m_last[k] = ia; m_ok[k] = 0; end
                    val = mem_word(ia);
                    if (ch_byte[k]) val = {8'h00, (a % 2 == 1) ? val[7:0] : val[15:8]};
                    capq.push_back('{cyc + 1 + LAT, k, val, !hit});
                end else if (code == 7) begin
                    e_ar = 1;
                end
                m_slot = sy ? 0 : (m_slot + 1) % SLOTS;
                m_cnt++;
                if (m_cnt >= RDYW) m_ready = 1;
            end
        end
        @(negedge clk);
        cyc++;
        if (sdram_rd === 1'b1) rdq.push_back('{cyc + LAT - 1, sdram_addr});
        for (int i = 0; i < CH; i++) edout[i*16 +: 16] = m_dout[i];
        chk("sdram_rd", sdram_rd, e_rd);
        chk("autorefresh", autorefresh, e_ar);
        chk("sdram_addr", sdram_addr, m_addr);
        chk("ch_valid", ch_valid, ev);
        chk("ch_dout", ch_dout, edout);
        chk("ready", ready, m_ready);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
    endtask

    task automatic map_all(input int ch);
        for (int s = 0; s < SLOTS; s++) slot_map[s*3 +: 3] = 3'(ch);
    endtask

    typedef struct {
        int ch; bit byt; logic [AW-1:0] addr, off; logic [15:0] data;
        logic [AW-1:0] exp_addr; logic [15:0] exp_dout;
    } vec_t;

    initial begin
        vec_t vt[6];
        bit [3:0] rd_pat, ar_pat;
        logic [15:0] w8;
        int got, nrd, p, dstart, dlen;
        bit sy, use_rst, in_burst;

        vt[0] = '{1, 1'b1, 22'h000005, 22'h00A000, 16'hA55A, 22'h00A002, 16'h005A};
        vt[1] = '{0, 1'b0, 22'h000123, 22'h000100, 16'h1234, 22'h000223, 16'h1234};
        vt[2] = '{2, 1'b0, 22'h000002, 22'h3FFFFF, 16'hBEEF, 22'h000001, 16'hBEEF};
        vt[3] = '{0, 1'b1, 22'h000010, 22'h000000, 16'hC3A5, 22'h000008, 16'h00C3};
        vt[4] = '{1, 1'b1, 22'h3FFFFF, 22'h000001, 16'h7E81, 22'h200000, 16'h0081};
        vt[5] = '{2, 1'b0, 22'h3FFFFF, 22'h3FFFFF, 16'h0F0F, 22'h3FFFFE, 16'h0F0F};

        @(negedge clk);
        do_reset();
        chk("reset_ready", ready, 1'b0);
        chk("reset_dout", ch_dout, '0);

        // address/data mapping vectors
        fixed_en = 1;
        foreach (vt[i]) begin
            set_ch(vt[i].ch, vt[i].addr, vt[i].off, vt[i].byt);
            map_all(vt[i].ch);
            fixed_data = vt[i].data;
            tick(1, 0, 0, 0);
            chk("tv_addr", sdram_addr, vt[i].exp_addr);
            idle(2);
            chk("tv_valid", ch_valid[vt[i].ch], 1'b1);
            chk("tv_dout", ch_dout[vt[i].ch*16 +: 16], vt[i].exp_dout);
            idle(1);
        end
        fixed_en = 0;

        // map {0,1,7,2}: reads in slots 0,1,3, refresh in slot 2
        do_reset();
        slot_map = {3'd2, 3'd7, 3'd1, 3'd0};
        rd_pat = 4'b1011;
        ar_pat = 4'b0100;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < CH; k++) set_ch(k, AW'(r*16 + k), '0, 1'b0);
            tick(1, 0, 0, 0);
            chk("t1_rd", sdram_rd, rd_pat[r % 4]);
            chk("t1_ar", autorefresh, ar_pat[r % 4]);
            tick(0, 0, 0, 0);
            chk("t1_valid_early", ch_valid[0], 1'b0);
            tick(0, 0, 0, 0);
            chk("t1_valid0", ch_valid[0], (r % 4) == 0);
            tick(0, 0, 0, 0);
        end

        // slot_sync while in slot 2
        do_reset();
        slot_map = {3'd2, 3'd7, 3'd1, 3'd0};
        set_ch(0, 22'h111, '0, 1'b0);
        set_ch(1, 22'h222, '0, 1'b0);
        set_ch(2, 22'h333, '0, 1'b0);
        tick(1, 0, 0, 0); idle(3);
        tick(1, 0, 0, 0); idle(3);
        tick(1, 1, 0, 0);
        chk("t3_ar", autorefresh, 1'b1);
        idle(3);
        set_ch(0, 22'h444, '0, 1'b0);
        tick(1, 0, 0, 0);
        chk("t3_rd", sdram_rd, 1'b1);
        chk("t3_addr", sdram_addr, 22'h444);
        idle(3);
        set_ch(1, 22'h555, '0, 1'b0);
        tick(1, 0, 0, 0);
        chk("t3_addr_next", sdram_addr, 22'h555);
        idle(3);

        // downloading one clock after a read
        do_reset();
        map_all(0);
        set_ch(0, 22'h1234, 22'h10, 1'b0);
        for (int i = 0; i < RDYW + 2; i++) begin tick(1, 0, 0, 0); idle(3); end
        chk("t4_ready_before", ready, 1'b1);
        set_ch(0, 22'h2345, 22'h10, 1'b0);
        tick(1, 0, 0, 0);
        chk("t4_rd", sdram_rd, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 0);
            chk("t4_no_valid", ch_valid, '0);
            chk("t4_ready_low", ready, 1'b0);
        end
        idle(2);
        chk("t4_no_late_valid", ch_valid, '0);
        got = -1;
        for (int i = 1; i <= RDYW + 4 && got < 0; i++) begin
            tick(1, 0, 0, 0);
            if (ready === 1'b1) got = i;
            idle(3);
        end
        chk("t4_ready_cens", got, RDYW);

        // same byte word twice: addr 0x10 then 0x11
        do_reset();
        map_all(0);
        nrd = 0;
        w8 = mem_word(22'h8);
        set_ch(0, 22'h10, '0, 1'b1);
        tick(1, 0, 0, 0); nrd += int'(sdram_rd);
        idle(2);
        chk("t6_dout_hi", ch_dout[15:0], {8'h00, w8[15:8]});
        idle(1);
        set_ch(0, 22'h11, '0, 1'b1);
        tick(1, 0, 0, 0); nrd += int'(sdram_rd);
        idle(2);
        chk("t6_dout_lo", ch_dout[15:0], {8'h00, w8[7:0]});
        chk("t6_valid", ch_valid[0], 1'b1);
        idle(1);
`ifdef JTGNG_ROMSLOT_REUSE_EN
        chk("t6_rd_count", nrd, 1);
`else
        chk("t6_rd_count", nrd, 2);
`endif

        // randomized traffic against the reference model
        do_reset();
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < CH; k++) begin
                    if ($urandom_range(0, 1) == 0)
                        set_ch(k, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 3)), 1'($urandom));
                    else
                        set_ch(k, AW'($urandom), AW'($urandom), 1'($urandom));
                end
                slot_map = 12'($urandom);
            end
            p  = $urandom_range(LAT + 1, LAT + 4);
            sy = ($urandom_range(0, 7) == 0);
            in_burst = ($urandom_range(0, 19) == 0);
            use_rst  = ($urandom_range(0, 3) == 0);
            dstart = $urandom_range(1, p - 1);
            dlen   = $urandom_range(1, p - dstart);
            tick(1, sy, 0, 0);
            for (int i = 1; i < p; i++) begin
                if (in_burst && i >= dstart && i < dstart + dlen)
                    tick(0, 0, !use_rst, use_rst);
                else
                    tick(0, 0, 0, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
